// File: rtl/led_panel_scan_pkg.sv
// led_panel_scan shared types and derived geometry.
// Scan states plus helpers deriving panel geometry from the bit widths.
package led_panel_scan_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_BLANK,
        S_LATCH,
        S_NEXT
    } state_t;

    localparam int DEF_COL_BITS = 5;
    localparam int DEF_ROW_BITS = 4;
    localparam int COLS         = 1 << DEF_COL_BITS;
    localparam int ROWS         = 1 << DEF_ROW_BITS;
    localparam int SHIFT_CYCLES = 2 * COLS + 2;

    function automatic int cols_of(input int col_bits);
        return 1 << col_bits;
    endfunction

    function automatic int rows_of(input int row_bits);
        return 1 << row_bits;
    endfunction

    function automatic int shift_cycles_of(input int col_bits);
        return 2 * (1 << col_bits) + 2;
    endfunction

endpackage

// File: rtl/led_panel_scan.sv
// HUB75 scan sequencer: shifts one row pair per pass, then blanks,
// latches and row-selects it while sweeping the shared PWM compare level.
module led_panel_scan
    import led_panel_scan_pkg::*;
#(
    parameter int PWM_WIDTH = 12,
    parameter int COL_BITS  = 5,
    parameter int ROW_BITS  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    output logic [PWM_WIDTH-1:0]         pwmlvl,
    output logic [ROW_BITS+COL_BITS-1:0] fb_addr,
    input  logic                         top_r,
    input  logic                         top_g,
    input  logic                         top_b,
    input  logic                         bot_r,
    input  logic                         bot_g,
    input  logic                         bot_b,
    output logic                         panel_r1,
    output logic                         panel_g1,
    output logic                         panel_b1,
    output logic                         panel_r2,
    output logic                         panel_g2,
    output logic                         panel_b2,
    output logic                         panel_clk,
    output logic                         panel_lat,
    output logic                         panel_oe_n,
    output logic [ROW_BITS-1:0]          panel_a,
    output logic                         frame_tick
);

    localparam int NCOLS = cols_of(COL_BITS);
    localparam int NROWS = rows_of(ROW_BITS);
    localparam int NSC   = shift_cycles_of(COL_BITS);
    localparam int CW    = $clog2(NSC);

    localparam logic [CW-1:0]       LAST_CYC = CW'(NSC - 1);
    localparam logic [CW-1:0]       ADDR_END = CW'(2 * NCOLS - 1);
    localparam logic [CW-1:0]       CAP_END  = CW'(2 * NCOLS);
    localparam logic [ROW_BITS-1:0] LAST_ROW = ROW_BITS'(NROWS - 1);

    state_t              state;
    logic [CW-1:0]       cnt;
    logic [CW-1:0]       cnt_nx;
    logic [ROW_BITS-1:0] srow;

    assign cnt_nx = cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            srow       <= '0;
            pwmlvl     <= '0;
            fb_addr    <= '0;
            panel_r1   <= 1'b0;
            panel_g1   <= 1'b0;
            panel_b1   <= 1'b0;
            panel_r2   <= 1'b0;
            panel_g2   <= 1'b0;
            panel_b2   <= 1'b0;
            panel_clk  <= 1'b0;
            panel_lat  <= 1'b0;
            panel_oe_n <= 1'b1;
            panel_a    <= '0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (enable) begin
                        state   <= S_SHIFT;
                        cnt     <= '0;
                        fb_addr <= {srow, {COL_BITS{1'b0}}};
                    end
                end
                S_SHIFT: begin
                    cnt <= cnt_nx;
                    // odd cycles: RAM data is valid, next column address goes out
                    if (cnt[0] && cnt < ADDR_END) begin
                        fb_addr <= {srow, cnt_nx[COL_BITS:1]};
                    end
                    if (cnt[0] && cnt < CAP_END) begin
                        panel_r1 <= top_r;
                        panel_g1 <= top_g;
                        panel_b1 <= top_b;
                        panel_r2 <= bot_r;
                        panel_g2 <= bot_g;
                        panel_b2 <= bot_b;
                    end
                    panel_clk <= ~cnt[0] && (cnt != '0);
                    if (cnt == LAST_CYC) begin
                        state      <= S_BLANK;
                        panel_oe_n <= 1'b1;
                    end
                end
                S_BLANK: begin
                    state     <= S_LATCH;
                    panel_lat <= 1'b1;
                    panel_a   <= srow;
                end
                S_LATCH: begin
                    state     <= S_NEXT;
                    panel_lat <= 1'b0;
                    srow      <= srow + 1'b1;
                    if (srow == LAST_ROW) begin
                        pwmlvl     <= pwmlvl + 1'b1;
                        frame_tick <= (pwmlvl == {PWM_WIDTH{1'b1}});
                    end
                end
                S_NEXT: begin
                    if (enable) begin
                        state      <= S_SHIFT;
                        cnt        <= '0;
                        fb_addr    <= {srow, {COL_BITS{1'b0}}};
                        panel_oe_n <= 1'b0;
                    end else begin
                        state      <= S_IDLE;
                        panel_oe_n <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_led_panel_scan.sv
// Directed bench for led_panel_scan with a 1-cycle RAM+comparator model.
// Runs with PWM_WIDTH=2 so a full PWM wrap fits in a short run.
module tb_led_panel_scan;

    localparam int PW   = 2;
    localparam int CB   = 5;
    localparam int RB   = 4;
    localparam int COLS = 32;
    localparam int SC   = 2 * COLS + 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic [PW-1:0] pwmlvl;
    logic [8:0]    fb_addr;
    logic          top_r, top_g, top_b;
    logic          bot_r, bot_g, bot_b;
    logic          panel_r1, panel_g1, panel_b1;
    logic          panel_r2, panel_g2, panel_b2;
    logic          panel_clk, panel_lat, panel_oe_n;
    logic [RB-1:0] panel_a;
    logic          frame_tick;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    led_panel_scan #(
        .PWM_WIDTH(PW),
        .COL_BITS (CB),
        .ROW_BITS (RB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .pwmlvl    (pwmlvl),
        .fb_addr   (fb_addr),
        .top_r     (top_r),
        .top_g     (top_g),
        .top_b     (top_b),
        .bot_r     (bot_r),
        .bot_g     (bot_g),
        .bot_b     (bot_b),
        .panel_r1  (panel_r1),
        .panel_g1  (panel_g1),
        .panel_b1  (panel_b1),
        .panel_r2  (panel_r2),
        .panel_g2  (panel_g2),
        .panel_b2  (panel_b2),
        .panel_clk (panel_clk),
        .panel_lat (panel_lat),
        .panel_oe_n(panel_oe_n),
        .panel_a   (panel_a),
        .frame_tick(frame_tick)
    );

    // framebuffer RAM + comparators, one cycle of latency
    always @(posedge clk) begin
        top_r <= fb_addr[0];
        top_g <= fb_addr[1];
        top_b <= 1'b0;
        bot_r <= fb_addr[CB];
        bot_g <= 1'b1;
        bot_b <= ~fb_addr[0];
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".pwm"}, 32'(pwmlvl), 0);
        chk({tag, ".addr"}, 32'(fb_addr), 0);
        chk({tag, ".data"}, 32'({panel_r1, panel_g1, panel_b1,
                                 panel_r2, panel_g2, panel_b2}), 0);
        chk({tag, ".pclk"}, 32'(panel_clk), 0);
        chk({tag, ".lat"}, 32'(panel_lat), 0);
        chk({tag, ".oe"}, 32'(panel_oe_n), 1);
        chk({tag, ".a"}, 32'(panel_a), 0);
        chk({tag, ".tick"}, 32'(frame_tick), 0);
    endtask

    // one row period, sampled on negedges; aborts early on rst_at
    task automatic row(input int r, input logic oe_sh, input int pl,
                       input int prev_a, input logic tick,
                       input int drop_at, input int rst_at);
        int edges;
        int k;
        logic prev_clk;
        edges    = 0;
        prev_clk = 1'b0;
        for (int i = 0; i < SC; i++) begin
            @(negedge clk);
            if (i % 2 == 0 && i < 2 * COLS)
                chk("addr", 32'(fb_addr), 32'((r << CB) | (i / 2)));
            chk("pclk", 32'(panel_clk), 32'(i % 2 == 1 && i >= 3));
            chk("oe_sh", 32'(panel_oe_n), 32'(oe_sh));
            chk("lat_sh", 32'(panel_lat), 0);
            chk("a_sh", 32'(panel_a), 32'(prev_a));
            chk("pwm_sh", 32'(pwmlvl), 32'(pl));
            chk("tick_sh", 32'(frame_tick), 0);
            if (i >= 2) begin
                k = (i - 2) / 2;
                chk("r1", 32'(panel_r1), 32'(k & 1));
                chk("g1", 32'(panel_g1), 32'((k >> 1) & 1));
                chk("b1", 32'(panel_b1), 0);
                chk("r2", 32'(panel_r2), 32'(r & 1));
                chk("g2", 32'(panel_g2), 1);
                chk("b2", 32'(panel_b2), 32'(~k & 1));
            end
            if (panel_clk && !prev_clk) edges++;
            prev_clk = panel_clk;
            if (i == drop_at) enable = 1'b0;
            if (i == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                chk_reset("midrst");
                rst = 1'b0;
                return;
            end
        end
        chk("nedge", 32'(edges), COLS);
        @(negedge clk);
        chk("blank.oe", 32'(panel_oe_n), 1);
        chk("blank.lat", 32'(panel_lat), 0);
        chk("blank.a", 32'(panel_a), 32'(prev_a));
        @(negedge clk);
        chk("latch.lat", 32'(panel_lat), 1);
        chk("latch.oe", 32'(panel_oe_n), 1);
        chk("latch.pclk", 32'(panel_clk), 0);
        chk("latch.a", 32'(panel_a), 32'(r));
        @(negedge clk);
        chk("next.lat", 32'(panel_lat), 0);
        chk("next.oe", 32'(panel_oe_n), 1);
        chk("next.tick", 32'(frame_tick), 32'(tick));
        chk("next.pwm", 32'(pwmlvl),
            32'(r == 15 ? (pl + 1) % (1 << PW) : pl));
    endtask

    initial begin
        int cnt_act;
        rst    = 1'b1;
        enable = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_reset("rst");

        cnt_act = 0;
        repeat (100) begin
            @(negedge clk);
            if (panel_clk || panel_lat || !panel_oe_n) cnt_act++;
        end
        chk("idle.act", 32'(cnt_act), 0);
        chk("idle.addr", 32'(fb_addr), 0);

        enable = 1'b1;
        for (int f = 0; f < 4; f++)
            for (int r = 0; r < 16; r++)
                row(r, (f == 0 && r == 0), f,
                    (f == 0 && r == 0) ? 0 : (r + 15) % 16,
                    (f == 3 && r == 15), -1, -1);

        for (int r = 0; r < 5; r++)
            row(r, 1'b0, 0, (r + 15) % 16, 1'b0, -1, -1);
        row(5, 1'b0, 0, 4, 1'b0, 30, -1);
        cnt_act = 0;
        repeat (10) begin
            @(negedge clk);
            if (panel_clk || panel_lat || !panel_oe_n) cnt_act++;
        end
        chk("drop.act", 32'(cnt_act), 0);
        chk("drop.a", 32'(panel_a), 5);
        chk("drop.oe", 32'(panel_oe_n), 1);

        enable = 1'b1;
        row(6, 1'b1, 0, 5, 1'b0, -1, -1);
        row(7, 1'b0, 0, 6, 1'b0, -1, 20);
        row(0, 1'b1, 0, 0, 1'b0, -1, -1);
        row(1, 1'b0, 0, 0, 1'b0, -1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/led_panel_scan.md
Name: led_panel_scan

Overview:
- Scan/refresh sequencer for the HUB75-style LED panel.
- Generates the shared PWM compare level `pwmlvl` and the framebuffer read address.
- Per-pixel compare bits come back from the external RGB PWM comparators: three for the top half-panel, three for the bottom.
- Shifts those bits into the panel, then latches, blanks and row-selects it.

Parameters:
PWM_WIDTH, 12, width of pwmlvl; must match comparator width
COL_BITS, 5, log2 of columns per row (COLS = 32)
ROW_BITS, 4, log2 of scanned row pairs (ROWS = 16; panel height 2*ROWS)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
enable  in  1  run scanning; sampled only at row boundaries
pwmlvl  out  PWM_WIDTH  compare level fed to all comparators
fb_addr  out  ROW_BITS+COL_BITS  framebuffer read address {row, col}; RAM read latency is exactly 1 cycle
top_r, top_g, top_b  in  1 each  comparator outputs for the top-half pixel at the previous cycle's fb_addr
bot_r, bot_g, bot_b  in  1 each  same for the bottom-half pixel (row + ROWS)
panel_r1, panel_g1, panel_b1, panel_r2, panel_g2, panel_b2  out  1 each  panel serial data
panel_clk  out  1  panel shift clock; panel samples on rising edge
panel_lat  out  1  panel latch strobe, active high
panel_oe_n  out  1  panel output enable, active low
panel_a  out  ROW_BITS  displayed row-pair select
frame_tick  out  1  1-cycle pulse when pwmlvl wraps to 0

Behaviour:
- All outputs are registered.
- Reset (synchronous, rst=1 at a rising edge):
  - pwmlvl=0, fb_addr=0, all panel data=0, panel_clk=0, panel_lat=0, panel_oe_n=1, panel_a=0, frame_tick=0.
  - Internal shift row = 0.
  - State = IDLE.
- Reset mid-operation aborts immediately with the same values; there is no partial-row completion.
- States:
  - IDLE: panel_oe_n=1. If enable=1, go to SHIFT, col=0.
  - SHIFT: lasts 2*COLS+2 cycles, counted as cycle c=0 upward.
    - Cycle 2k (k<COLS): fb_addr={shift_row,k}.
    - Cycle 2k+1: RAM/comparator bits valid; registered at end of cycle.
    - Data for column k is stable on panel_* data in cycles 2k+2 and 2k+3.
    - panel_clk=1 in cycle 2k+3 only, else 0.
    - Exactly COLS rising edges of panel_clk per SHIFT.
    - panel_oe_n keeps its pre-SHIFT value: the previous row is displayed during the shift.
  - BLANK (1 cycle): panel_oe_n=1.
  - LATCH (1 cycle): panel_lat=1, panel_a=shift_row, panel_oe_n=1.
  - NEXT (1 cycle), deciding the next shift row:
    - If shift_row==ROWS-1: shift_row=0 and pwmlvl=pwmlvl+1 (mod 2^PWM_WIDTH).
      - On wrap to 0, frame_tick=1 for this cycle.
    - Else shift_row+1.
    - If enable=1: panel_oe_n=0 and go to SHIFT.
    - Else: panel_oe_n stays 1 and go to IDLE.
- Row period = 2*COLS+5 cycles. Display time per row = 2*COLS+2 cycles (oe_n low during the following SHIFT).
- The first SHIFT after IDLE has oe_n=1, so no stale row is shown.
- enable deasserted mid-SHIFT has no effect until NEXT.
- enable is ignored in BLANK/LATCH.
- panel_lat and panel_clk are never high in the same cycle.
- panel_lat is only high while panel_oe_n=1.
- panel_a changes only in LATCH.
- pwmlvl is constant within a full frame of ROWS rows. It changes only in NEXT after row ROWS-1.
- Comparator bits are passed through without inversion; the block does no arithmetic on pixel data.

Decomposition:
- Shared package holds:
  - State encoding (IDLE, SHIFT, BLANK, LATCH, NEXT).
  - Derived constants COLS=1<<COL_BITS, ROWS=1<<ROW_BITS, SHIFT_CYCLES=2*COLS+2.
- Single module, no sub-module; the SHIFT phase counter is inline.
- Top level instantiates six comparator instances between the RAM and this block, sharing pwmlvl.

Test Plan:
- Reset behaviour: rst=1 for 3 cycles, then release with enable=0 -> all outputs at reset values; stays IDLE for 100 cycles; no panel_clk edges.
- Column addressing and data delivery:
  - Stimulus: enable=1 from reset; model RAM+comparator returns top_r=col[0], bot_b=~col[0].
  - Required: 32 panel_clk rising edges in first SHIFT.
  - At rising edge k: panel_r1=k&1, panel_b2=~k&1.
  - fb_addr = {0,k} at cycle 2k.
- Latch/row sequencing:
  - Over the first 16 rows: panel_lat pulses every 69 cycles.
  - panel_a steps 0,1,...,15,0.
  - panel_oe_n=1 for the whole first SHIFT, then low in SHIFT phases, high in BLANK/LATCH.
- PWM wrap, with PWM_WIDTH=2 override:
  - pwmlvl sequence 0,1,2,3,0, each held for 16 rows.
  - frame_tick is a single pulse at the 3->0 transition.
- Enable drop mid-SHIFT at row 5 -> the row completes its shift and latch (panel_a=5), then enters IDLE with panel_oe_n=1. Re-enable resumes at shift row 6.
- Reset mid-SHIFT at column 10 -> next cycle: all outputs at reset values, panel_lat never pulses, and the restart begins at fb_addr=0.
